// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Purpose:
//   Resolves three kinds of hazard and drives the stall (hold) and flush
//   (bubble) controls of the PC and the segment registers:
//     * memory wait   : MEM-stage data access not acknowledged -> freeze the
//                       whole pipeline and bubble MEM/WB until dm_ack.
//     * load-use      : EX holds a load whose destination an ID source needs
//                       -> hold PC and IF/ID for one cycle, bubble ID/EX.
//     * redirect      : taken branch/jal/jalr resolved in EX -> squash the
//                       two younger instructions (IF/ID and ID/EX).
//   Also selects the operand forwarding source for both ID source registers.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_rf_ra0/1, id_rf_re0/1  ID source register addresses / read enables
//   ex_rf_wa/we, ex_rf_wd_sel EX destination, write enable, writeback select
//                             (2'b10 = load)
//   mem_rf_wa/we, wb_rf_wa/we MEM and WB destinations / write enables
//   ex_pc_sel                 nonzero = taken redirect resolved in EX
//   dm_req, dm_ack            MEM-stage access pending / memory done
//   stall_if/id/ex/mem        hold PC, IF/ID, ID/EX, EX/MEM
//   flush_id/ex/mem/wb        bubble IF/ID, ID/EX, EX/MEM, MEM/WB
//   fwd_sel0/1                0 = RF, 1 = MEM ALU result, 2 = WB write data
//   mem_wait, wait_cnt        FSM in WAIT / cycles spent in current WAIT
//   dm_timeout                sticky: a WAIT lasted 255 cycles or more
//
// Configuration:
//   HAZARD_PERF_EN  adds 32-bit wrapping counters stall_cycles, lu_count and
//                   redirect_count (memory-stall, load-use and redirect
//                   cycles). Undefined by default.
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rf_ra0,
    input  logic [4:0] id_rf_ra1,
    input  logic       id_rf_re0,
    input  logic       id_rf_re1,
    input  logic [4:0] ex_rf_wa,
    input  logic       ex_rf_we,
    input  logic [1:0] ex_rf_wd_sel,
    input  logic [4:0] mem_rf_wa,
    input  logic       mem_rf_we,
    input  logic [4:0] wb_rf_wa,
    input  logic       wb_rf_we,
    input  logic [1:0] ex_pc_sel,
    input  logic       dm_req,
    input  logic       dm_ack,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       flush_mem,
    output logic       flush_wb,
    output logic [1:0] fwd_sel0,
    output logic [1:0] fwd_sel1,
    output logic       mem_wait,
    output logic [7:0] wait_cnt,
    output logic       dm_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] lu_count,
    output logic [31:0] redirect_count
`endif
);

    localparam logic [1:0] WD_SEL_LOAD = 2'b10;
    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;
    localparam logic [7:0] CNT_MAX     = 8'hFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       dm_timeout_q, dm_timeout_d;

    logic mem_stall;
    logic redirect;
    logic lu_match;
    logic lu_stall;
    logic redirect_act;

    // -------------------------------------------------------------------------
    // Next-state logic for the memory-wait FSM and its counters
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dm_timeout_d = dm_timeout_q;

        unique case (state_q)
            ST_RUN: begin
                // dm_req with dm_ack in the same cycle is a zero-wait access.
                if (dm_req && !dm_ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (dm_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Sticky: set on the same edge wait_cnt reaches its ceiling; the FSM
        // itself keeps waiting for dm_ack.
        if (wait_cnt_d == CNT_MAX) begin
            dm_timeout_d = 1'b1;
        end
    end

    // NOTE: the reset is asynchronous, so rst appears in the sensitivity list
    // and a mid-WAIT reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            dm_timeout_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dm_timeout_q <= dm_timeout_d;
        end
    end

    assign mem_wait   = (state_q == ST_WAIT);
    assign wait_cnt   = wait_cnt_q;
    assign dm_timeout = dm_timeout_q;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    // Frozen while waiting, and also in the RUN cycle that is about to leave
    // for WAIT, so the access in MEM is held in place from its first cycle.
    assign mem_stall = (state_q == ST_WAIT) || (dm_req && !dm_ack);

    assign redirect = (ex_pc_sel != 2'b00);

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu_match = (ex_rf_wd_sel == WD_SEL_LOAD) && ex_rf_we &&
                      (ex_rf_wa != 5'd0) &&
                      ((id_rf_re0 && (id_rf_ra0 == ex_rf_wa)) ||
                       (id_rf_re1 && (id_rf_ra1 == ex_rf_wa)));

    // A redirect squashes the dependent instruction in ID, so its load-use
    // stall would only delay the fetch of the correct target.
    assign redirect_act = !mem_stall && redirect;
    assign lu_stall     = !mem_stall && !redirect && lu_match;

    // -------------------------------------------------------------------------
    // Forwarding: MEM is younger than WB, so it wins when both match.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] fwd_pick(input logic [4:0] ra);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_rf_we && (mem_rf_wa != 5'd0) && (mem_rf_wa == ra)) begin
            sel = FWD_MEM;
        end else if (wb_rf_we && (wb_rf_wa != 5'd0) && (wb_rf_wa == ra)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // -------------------------------------------------------------------------
    // Stall / flush / forward outputs. Priority: reset, memory wait,
    // redirect, load-use. No branch asserts a stall and a flush on the same
    // segment register.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;
        fwd_sel0  = FWD_RF;
        fwd_sel1  = FWD_RF;

        if (rst) begin
            // Bubble every segment register while in reset.
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            flush_wb  = 1'b1;
        end else begin
            fwd_sel0 = fwd_pick(id_rf_ra0);
            fwd_sel1 = fwd_pick(id_rf_ra1);

            if (mem_stall) begin
                // Freeze everything up to EX/MEM; WB must not retire the
                // pending access twice, so MEM/WB takes a bubble.
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                flush_wb  = 1'b1;
            end else if (redirect_act) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (lu_stall) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // -------------------------------------------------------------------------
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] lu_count_q, lu_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        stall_cycles_d   = stall_cycles_q + {31'd0, mem_stall};
        lu_count_d       = lu_count_q + {31'd0, lu_stall};
        redirect_count_d = redirect_count_q + {31'd0, redirect_act};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q   <= '0;
            lu_count_q       <= '0;
            redirect_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            lu_count_q       <= lu_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign lu_count       = lu_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 unit
// later, well clear of both clock edges.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rf_ra0, id_rf_ra1;
    logic       id_rf_re0, id_rf_re1;
    logic [4:0] ex_rf_wa, mem_rf_wa, wb_rf_wa;
    logic       ex_rf_we, mem_rf_we, wb_rf_we;
    logic [1:0] ex_rf_wd_sel, ex_pc_sel;
    logic       dm_req, dm_ack;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_mem, flush_wb;
    logic [1:0] fwd_sel0, fwd_sel1;
    logic       mem_wait;
    logic [7:0] wait_cnt;
    logic       dm_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, lu_count, redirect_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rf_ra0    (id_rf_ra0),
        .id_rf_ra1    (id_rf_ra1),
        .id_rf_re0    (id_rf_re0),
        .id_rf_re1    (id_rf_re1),
        .ex_rf_wa     (ex_rf_wa),
        .ex_rf_we     (ex_rf_we),
        .ex_rf_wd_sel (ex_rf_wd_sel),
        .mem_rf_wa    (mem_rf_wa),
        .mem_rf_we    (mem_rf_we),
        .wb_rf_wa     (wb_rf_wa),
        .wb_rf_we     (wb_rf_we),
        .ex_pc_sel    (ex_pc_sel),
        .dm_req       (dm_req),
        .dm_ack       (dm_ack),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .flush_mem    (flush_mem),
        .flush_wb     (flush_wb),
        .fwd_sel0     (fwd_sel0),
        .fwd_sel1     (fwd_sel1),
        .mem_wait     (mem_wait),
        .wait_cnt     (wait_cnt),
        .dm_timeout   (dm_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .lu_count       (lu_count),
        .redirect_count (redirect_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed views: {if,id,ex,mem} and {id,ex,mem,wb}.
    task automatic check_ctl(input string tag, input logic [3:0] exp_stall, input logic [3:0] exp_flush);
        check({tag, ".stall"}, {28'd0, stall_if, stall_id, stall_ex, stall_mem}, {28'd0, exp_stall});
        check({tag, ".flush"}, {28'd0, flush_id, flush_ex, flush_mem, flush_wb}, {28'd0, exp_flush});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        id_rf_ra0 = 5'd0; id_rf_ra1 = 5'd0; id_rf_re0 = 1'b0; id_rf_re1 = 1'b0;
        ex_rf_wa = 5'd0; ex_rf_we = 1'b0; ex_rf_wd_sel = 2'b00;
        mem_rf_wa = 5'd0; mem_rf_we = 1'b0; wb_rf_wa = 5'd0; wb_rf_we = 1'b0;
        ex_pc_sel = 2'b00; dm_req = 1'b0; dm_ack = 1'b0;
    endtask

    // EX: lw x5 ; ID: add x6, x5, x1
    task automatic load_use_inputs();
        ex_rf_wd_sel = 2'b10; ex_rf_we = 1'b1; ex_rf_wa = 5'd5;
        id_rf_re0 = 1'b1; id_rf_ra0 = 5'd5; id_rf_re1 = 1'b1; id_rf_ra1 = 5'd1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        mem_rf_we = 1'b1; mem_rf_wa = 5'd7; id_rf_ra0 = 5'd7;  // would forward if not in reset
        settle();
        check_ctl("reset", 4'b0000, 4'b1111);
        check("reset.fwd0", {30'd0, fwd_sel0}, 32'd0);
        check("reset.mem_wait", {31'd0, mem_wait}, 32'd0);
        check("reset.wait_cnt", {24'd0, wait_cnt}, 32'd0);
        check("reset.timeout", {31'd0, dm_timeout}, 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        check_ctl("idle", 4'b0000, 4'b0000);

        // ---------------- load-use ----------------
        load_use_inputs();
        settle();
        check_ctl("lu", 4'b1100, 4'b0100);
        tick();
        // Bubble now in EX, load in MEM.
        idle_inputs();
        id_rf_re0 = 1'b1; id_rf_ra0 = 5'd5; id_rf_re1 = 1'b1; id_rf_ra1 = 5'd1;
        mem_rf_we = 1'b1; mem_rf_wa = 5'd5;
        settle();
        check_ctl("lu_next", 4'b0000, 4'b0000);
        check("lu_next.fwd0", {30'd0, fwd_sel0}, 32'd1);
        check("lu_next.fwd1", {30'd0, fwd_sel1}, 32'd0);

        // Source 1 matches the load but is not read: no stall.
        idle_inputs();
        ex_rf_wd_sel = 2'b10; ex_rf_we = 1'b1; ex_rf_wa = 5'd5;
        id_rf_re1 = 1'b0; id_rf_ra1 = 5'd5; id_rf_re0 = 1'b1; id_rf_ra0 = 5'd3;
        settle();
        check_ctl("lu_re_off", 4'b0000, 4'b0000);

        // ---------------- redirect beats load-use ----------------
        idle_inputs();
        load_use_inputs();
        ex_pc_sel = 2'b01;
        settle();
        check_ctl("redirect", 4'b0000, 4'b1100);
        tick();
`ifdef HAZARD_PERF_EN
        check("perf.lu_count", lu_count, 32'd1);
        check("perf.redirect_count", redirect_count, 32'd1);
`endif

        // ---------------- forwarding priority and x0 ----------------
        idle_inputs();
        mem_rf_we = 1'b1; mem_rf_wa = 5'd7; wb_rf_we = 1'b1; wb_rf_wa = 5'd7;
        id_rf_ra0 = 5'd7; id_rf_ra1 = 5'd7; id_rf_re0 = 1'b1; id_rf_re1 = 1'b1;
        settle();
        check("fwd_prio.fwd0", {30'd0, fwd_sel0}, 32'd1);
        check("fwd_prio.fwd1", {30'd0, fwd_sel1}, 32'd1);
        mem_rf_wa = 5'd8;
        settle();
        check("fwd_wb.fwd0", {30'd0, fwd_sel0}, 32'd2);
        idle_inputs();
        mem_rf_we = 1'b1; mem_rf_wa = 5'd0; wb_rf_we = 1'b1; wb_rf_wa = 5'd0;
        ex_rf_wd_sel = 2'b10; ex_rf_we = 1'b1; ex_rf_wa = 5'd0;
        id_rf_re0 = 1'b1; id_rf_ra0 = 5'd0; id_rf_re1 = 1'b1; id_rf_ra1 = 5'd0;
        settle();
        check("x0.fwd0", {30'd0, fwd_sel0}, 32'd0);
        check("x0.fwd1", {30'd0, fwd_sel1}, 32'd0);
        check_ctl("x0", 4'b0000, 4'b0000);

        // ---------------- zero-wait access ----------------
        idle_inputs();
        dm_req = 1'b1; dm_ack = 1'b1;
        settle();
        check_ctl("zero_wait", 4'b0000, 4'b0000);
        tick();
        check("zero_wait.mem_wait", {31'd0, mem_wait}, 32'd0);

        // ---------------- memory wait (3 cycles) ----------------
        idle_inputs();
        dm_req = 1'b1; dm_ack = 1'b0;
        settle();
        check_ctl("wait_enter", 4'b1111, 4'b0001);
        check("wait_enter.mem_wait", {31'd0, mem_wait}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) load_use_inputs();   // load-use must be masked by the freeze
            if (i == 2) begin
                idle_inputs();
                dm_req = 1'b1; dm_ack = 1'b1;
            end
            settle();
            check($sformatf("wait%0d.mem_wait", i), {31'd0, mem_wait}, 32'd1);
            check($sformatf("wait%0d.cnt", i), {24'd0, wait_cnt}, i);
            check_ctl($sformatf("wait%0d", i), 4'b1111, 4'b0001);
            tick();
        end
        idle_inputs();
        settle();
        check("wait_exit.mem_wait", {31'd0, mem_wait}, 32'd0);
        check("wait_exit.cnt", {24'd0, wait_cnt}, 32'd0);
        check_ctl("wait_exit", 4'b0000, 4'b0000);

        // ---------------- timeout ----------------
        dm_req = 1'b1; dm_ack = 1'b0;
        tick();                                  // now in WAIT, wait_cnt = 0
        repeat (254) tick();
        check("to254.cnt", {24'd0, wait_cnt}, 32'd254);
        check("to254.timeout", {31'd0, dm_timeout}, 32'd0);
        tick();
        check("to255.cnt", {24'd0, wait_cnt}, 32'd255);
        check("to255.timeout", {31'd0, dm_timeout}, 32'd1);
        repeat (45) tick();
        check("to_sat.cnt", {24'd0, wait_cnt}, 32'd255);
        check("to_sat.mem_wait", {31'd0, mem_wait}, 32'd1);
        dm_ack = 1'b1;
        tick();
        idle_inputs();
        settle();
        check("to_after_ack.mem_wait", {31'd0, mem_wait}, 32'd0);
        check("to_after_ack.timeout", {31'd0, dm_timeout}, 32'd1);

        // ---------------- asynchronous reset mid-WAIT ----------------
        dm_req = 1'b1; dm_ack = 1'b0;
        tick();
        tick();
        check("rw.mem_wait", {31'd0, mem_wait}, 32'd1);
        check("rw.cnt", {24'd0, wait_cnt}, 32'd1);
        rst = 1'b1;                              // between edges
        settle();
        check("rw_rst.mem_wait", {31'd0, mem_wait}, 32'd0);
        check("rw_rst.cnt", {24'd0, wait_cnt}, 32'd0);
        check("rw_rst.timeout", {31'd0, dm_timeout}, 32'd0);
        check_ctl("rw_rst", 4'b0000, 4'b1111);
`ifdef HAZARD_PERF_EN
        check("rw_rst.stall_cycles", stall_cycles, 32'd0);
        check("rw_rst.lu_count", lu_count, 32'd0);
        check("rw_rst.redirect_count", redirect_count, 32'd0);
`endif
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst.mem_wait", {31'd0, mem_wait}, 32'd0);
        check_ctl("post_rst", 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: id_rf_ra0/id_rf_ra1 in 5 each, ID-stage source register addresses.
REQ-004 SHALL have ports: id_rf_re0/id_rf_re1 in 1 each, ID-stage source read enables.
REQ-005 SHALL have ports: ex_rf_wa, mem_rf_wa, wb_rf_wa in 5 each; ex_rf_we, mem_rf_we, wb_rf_we in 1 each.
REQ-006 SHALL have port: ex_rf_wd_sel in 2; value 2'b10 marks a load in EX.
REQ-007 SHALL have port: ex_pc_sel in 2; any nonzero value is a taken redirect (branch, jal or jalr) resolved in EX.
REQ-008 SHALL have ports: dm_req in 1 (MEM-stage access pending) and dm_ack in 1 (memory done).
REQ-009 SHALL have outputs: stall_if, stall_id, stall_ex, stall_mem (1 each), the hold controls for the PC and the IF/ID, ID/EX and EX/MEM segment registers.
REQ-010 SHALL have outputs: flush_id, flush_ex, flush_mem, flush_wb (1 each), the bubble controls for the segment registers.
REQ-011 SHALL have outputs: fwd_sel0, fwd_sel1 (2 each), with 0 = RF, 1 = MEM-stage ALU result, 2 = WB write data; value 3 is never driven.
REQ-012 SHALL have outputs: mem_wait in 1 (FSM in WAIT), wait_cnt in 8 (cycles spent in the current WAIT) and dm_timeout in 1 (sticky).

Function
REQ-013 SHALL implement a two-state FSM: RUN and WAIT.
REQ-014 RUN->WAIT when dm_req=1 and dm_ack=0; WAIT->RUN on dm_ack=1; dm_req=1 with dm_ack=1 in RUN stays in RUN (zero-wait access).
REQ-015 In WAIT, or in RUN when it is leaving to WAIT, SHALL assert all four stall_* and flush_wb, and hold every other flush_* at 0.
REQ-016 wait_cnt SHALL clear on entry to WAIT, increment by 1 per WAIT cycle, saturate at 255, and clear on return to RUN.
REQ-017 dm_timeout SHALL set when wait_cnt reaches 255 and stay set until rst; the FSM keeps waiting for dm_ack.
REQ-018 Load-use, when not memory-stalled: an EX load with ex_rf_we=1, ex_rf_wa!=0, and ex_rf_wa matching an enabled ID source SHALL assert stall_if, stall_id and flush_ex for exactly one cycle.
REQ-019 Redirect, when not memory-stalled: ex_pc_sel!=0 SHALL assert flush_id and flush_ex and suppress any simultaneous load-use stall, because the dependent instruction is on the wrong path.
REQ-020 A stall_* and a flush_* for the same segment register SHALL never be asserted in the same cycle.
REQ-021 Forwarding per source i: mem_rf_we=1, mem_rf_wa!=0 and mem_rf_wa==ra_i -> 1; else the same test on WB -> 2; else 0. MEM SHALL take priority over WB.
REQ-022 Register x0 SHALL never be forwarded or stalled on.
REQ-023 Stall, flush and forwarding outputs SHALL be combinational from inputs and FSM state; the FSM and counters SHALL be registered.

Reset
REQ-024 While rst=1, SHALL force: FSM to RUN, wait_cnt=0, dm_timeout=0, all stall_*=0, all flush_*=1 and fwd_sel*=0.
REQ-025 Reset asserted during WAIT SHALL abandon the wait immediately, with no ack required.

Configuration
REQ-026 Macro HAZARD_PERF_EN SHALL add three outputs: stall_cycles 32, lu_count 32 and redirect_count 32.
REQ-027 With HAZARD_PERF_EN, the counters SHALL increment on memory-stall cycles, load-use stall cycles and redirect cycles respectively. They SHALL wrap modulo 2^32 and clear on rst.
REQ-028 Without HAZARD_PERF_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Test load-use: EX lw x5, with ID add x6,x5,x1 (re0=1, ra0=5) -> stall_if=stall_id=flush_ex=1 for 1 cycle; next cycle, with the load in MEM, fwd_sel0=1.
REQ-030 Test redirect: ex_pc_sel=2'b01 together with a load-use match -> flush_id=flush_ex=1, stall_if=stall_id=0.
REQ-031 Test memory wait: dm_req=1, dm_ack=0 for 3 cycles, then dm_ack=1 -> mem_wait=1 and all stall_*=1 plus flush_wb=1 for 3 cycles, wait_cnt 0,1,2, then RUN.
REQ-032 Test timeout: dm_req=1 with no ack for 300 cycles -> wait_cnt holds at 255 and dm_timeout=1; it stays set after ack until rst.
REQ-033 Test forward priority and x0: MEM and WB both write x7 while ID reads x7 -> fwd_sel=1; ID reads x0 while MEM writes x0 -> fwd_sel=0 with no stall.
REQ-034 Test reset mid-WAIT: assert rst asynchronously during WAIT -> FSM=RUN, wait_cnt=0, stalls deasserted with no clock edge; with HAZARD_PERF_EN, counters read 0.
